mac_seq_ctrl: RTL

- Sequencer for the parallel array of Q16.16 multiply-accumulate cells.
- On a start request, it performs one dot-product pass of runtime length len:
  - clears all cells;
  - streams read addresses to the operand memories;
  - asserts the cell enable aligned to the memory read latency;
  - pulses done once every cell result register holds the final sum.
- Sits between the network-evaluation control and the MAC array and memories. The enable and clear outputs are broadcast to all cells.

---
 rtl/mac_pkg.sv | 20 ++
 rtl/lat_pipe.sv | 38 +++
 rtl/mac_seq_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC-array sequencer.
//   state_e      sequencer states
//   FX_*         Q16.16 word layout used by the MAC cells
//   DEF_MAX_LEN  default maximum dot-product length
package mac_pkg;

  localparam int FX_INT      = 16;
  localparam int FX_FRAC     = 16;
  localparam int FX_W        = FX_INT + FX_FRAC;
  localparam int DEF_MAX_LEN = 256;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/lat_pipe.sv
// Valid-bit shift register that mirrors the operand memory read latency.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   flush_i     synchronous clear of every stage (wins over in_i)
//   in_i        valid bit entering the pipe
//   tail_o      valid bit leaving the pipe, DEPTH cycles after in_i
//   empty_o     no valid bit behind the tail stage, so the pipe is empty
//               next cycle unless in_i is set
module lat_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic in_i,
  output logic tail_o,
  output logic empty_o
);

  // Every stage except the tail.
  localparam logic [DEPTH-1:0] BODY_MASK = {DEPTH{1'b1}} >> 1;

  logic [DEPTH-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d = (pipe_q << 1) | DEPTH'(in_i);
    if (flush_i) pipe_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_q <= '0;
    else        pipe_q <= pipe_d;
  end

  assign tail_o  = pipe_q[DEPTH-1];
  assign empty_o = ~|(pipe_q & BODY_MASK);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer for the parallel Q16.16 MAC array: one dot-product pass per
// accepted start (clear cells, stream operand addresses, enable cells
// RD_LAT cycles after each read, pulse done when results are final).
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start_i      pass request, sampled in IDLE only
//   len_i        pass length 0..MAX_LEN (larger values saturate)
//   hold_i       operand source not ready, suspends address issue
//   abort_i      synchronous cancel, back to IDLE without done
//   busy_o       pass in progress (CLEAR, RUN, DRAIN)
//   mac_clr_o    broadcast clear to the cells
//   mac_en_o     broadcast accumulate enable to the cells
//   rd_en_o      operand read strobe
//   rd_addr_o    operand index, holds its last value between reads
//   done_o       one-cycle pulse, array results are final
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | one-cycle clear of all cells
// RUN   | issuing reads 0..len-1, stalled by hold
// DRAIN | reads in flight still reaching the cells
// DONE  | done pulse, back to IDLE
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int RD_LAT  = 1,
  parameter int AW      = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [AW:0]   len_i,
  input  logic          hold_i,
  input  logic          abort_i,
  output logic          busy_o,
  output logic          mac_clr_o,
  output logic          mac_en_o,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_o,
  output logic          done_o
);

  localparam logic [AW:0] LEN_MAX = (AW+1)'(MAX_LEN);

  state_e        state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          pipe_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      count_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    count_d   = count_q;
    addr_d    = addr_q;
    busy_o    = 1'b0;
    mac_clr_o = 1'b0;
    rd_en_o   = 1'b0;
    done_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          len_d   = (len_i > LEN_MAX) ? LEN_MAX : len_i;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        busy_o    = 1'b1;
        mac_clr_o = 1'b1;
        count_d   = '0;
        addr_d    = '0;
        state_d   = (len_q == '0) ? DONE : RUN;
      end
      RUN: begin
        busy_o = 1'b1;
        if (!hold_i) begin
          rd_en_o = 1'b1;
          addr_d  = count_q[AW-1:0];
          count_d = count_q + 1'b1;
          if (count_q + 1'b1 == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy_o = 1'b1;
        // Tail holds the final enable this cycle (or already left).
        if (pipe_empty) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides every transition, including a start seen in IDLE.
    if (abort_i) state_d = IDLE;
  end

  // Live index while reading, otherwise the last index issued.
  assign rd_addr_o = rd_en_o ? count_q[AW-1:0] : addr_q;

  lat_pipe #(
    .DEPTH (RD_LAT)
  ) u_lat_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (abort_i),
    .in_i    (rd_en_o),
    .tail_o  (mac_en_o),
    .empty_o (pipe_empty)
  );

endmodule
